decoder_scan_ctrl: RTL and testbench

Sequential row-scan controller that sits directly upstream of the `bin2onehot` decoder. It drives the decoder's k-bit index and enable inputs so that a programmed window of one-hot lines is asserted one at a time, each for a programmable dwell time. The scan runs either as a single pass or continuously, with start/busy/done handshaking toward the controlling logic.

---
 rtl/decoder_scan_pkg.sv | 20 ++
 rtl/decoder_scan_ctrl_dwell_timer.sv | 28 ++
 rtl/decoder_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: state encoding and default widths shared by the
// decoder row-scan controller and its dwell timer.
package decoder_scan_pkg;

   localparam int K_DEF       = 6;
   localparam int DWELL_W_DEF = 8;

   localparam logic [1:0] ENC_IDLE  = 2'd0;
   localparam logic [1:0] ENC_ROW   = 2'd1;
   localparam logic [1:0] ENC_BLANK = 2'd2;
   localparam logic [1:0] ENC_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ENC_IDLE,
      ST_ROW   = ENC_ROW,
      ST_BLANK = ENC_BLANK,
      ST_DONE  = ENC_DONE
   } scan_state_t;

endpackage

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// dwell_timer: loadable down-counter measuring how long a row stays enabled.
// A loaded value of 0 behaves like 1, so every row gets at least one cycle.
module dwell_timer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] value,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q;

   // Reload on row entry, otherwise count down and park at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (cnt_q > DWELL_W'(1)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expire = (cnt_q <= DWELL_W'(1));

endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives index/enable of a bin2onehot decoder so that a
// window first..last (wrapping modulo 2^K) is enabled one row at a time.
// Optional macro DECODER_SCAN_BLANK_EN inserts a one-cycle blank between rows.
module decoder_scan_ctrl
   import decoder_scan_pkg::*;
#(
   parameter int K       = K_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               start_i,
   input  logic [K-1:0]       first_i,
   input  logic [K-1:0]       last_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic               cont_i,
   input  logic               abort_i,
   output logic [K-1:0]       idx_o,
   output logic               en_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               wrap_o
);

   scan_state_t        state_q, state_n;
   logic [K-1:0]       idx_n;
   logic               en_n, busy_n, done_n, wrap_n;
   logic               load, latch, expire;
   logic [DWELL_W-1:0] dwell_val;

   logic [K-1:0]       first_q, last_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               cont_q;

`ifdef DECODER_SCAN_BLANK_EN
   // The wrap is announced on the first enabled cycle after the blank.
   logic               wrap_pend_q, wrap_pend_n;
`endif

   // At start the timer must see the incoming dwell, not the stale copy.
   assign dwell_val = latch ? dwell_i : dwell_q;

   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .load   (load),
      .value  (dwell_val),
      .expire (expire)
   );

   // Scan configuration captured once per accepted start.
   always_ff @(posedge wb_clk_i) begin
      if (latch) begin
         first_q <= first_i;
         last_q  <= last_i;
         dwell_q <= dwell_i;
         cont_q  <= cont_i;
      end
   end

   // State and registered outputs.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         idx_o   <= '0;
         en_o    <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         wrap_o  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_o   <= idx_n;
         en_o    <= en_n;
         busy_o  <= busy_n;
         done_o  <= done_n;
         wrap_o  <= wrap_n;
      end
   end

`ifdef DECODER_SCAN_BLANK_EN
   // Remembers that the row being blanked into is a wrap back to first.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) wrap_pend_q <= 1'b0;
      else          wrap_pend_q <= wrap_pend_n;
   end
`endif

   // Next state and next registered output values; abort overrides all.
   always_comb begin
      state_n = state_q;
      idx_n   = idx_o;
      en_n    = 1'b0;
      busy_n  = 1'b1;
      done_n  = 1'b0;
      wrap_n  = 1'b0;
      load    = 1'b0;
      latch   = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      wrap_pend_n = wrap_pend_q;
`endif
      case (state_q)
         ST_IDLE: begin
            busy_n = 1'b0;
            if (start_i) begin
               latch   = 1'b1;
               load    = 1'b1;
               idx_n   = first_i;
               state_n = ST_ROW;
               en_n    = 1'b1;
               busy_n  = 1'b1;
            end
         end
         ST_ROW: begin
            en_n = 1'b1;
            if (expire) begin
               if ((idx_o != last_q) || cont_q) begin
                  if (idx_o != last_q) idx_n = idx_o + 1'b1;
                  else                 idx_n = first_q;
`ifdef DECODER_SCAN_BLANK_EN
                  state_n     = ST_BLANK;
                  en_n        = 1'b0;
                  wrap_pend_n = (idx_o == last_q);
`else
                  load   = 1'b1;
                  wrap_n = (idx_o == last_q);
`endif
               end else begin
                  state_n = ST_DONE;
                  en_n    = 1'b0;
                  done_n  = 1'b1;
               end
            end
         end
`ifdef DECODER_SCAN_BLANK_EN
         ST_BLANK: begin
            state_n     = ST_ROW;
            load        = 1'b1;
            en_n        = 1'b1;
            wrap_n      = wrap_pend_q;
            wrap_pend_n = 1'b0;
         end
`endif
         ST_DONE: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase
      if (abort_i) begin
         state_n = ST_IDLE;
         idx_n   = idx_o;
         en_n    = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b0;
         wrap_n  = 1'b0;
         load    = 1'b0;
         latch   = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
         wrap_pend_n = 1'b0;
`endif
      end
   end

`ifdef FORMAL
   // Output invariants: enable only while busy, pulses exclusive, index in window.
   always_comb begin
      if (!wb_rst_i) begin
         assert (!en_o || busy_o);
         assert (!(done_o && wrap_o));
         assert (!en_o || ((first_q <= last_q) ? ((idx_o >= first_q) && (idx_o <= last_q))
                                              : ((idx_o >= first_q) || (idx_o <= last_q))));
      end
   end
`endif

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed bench for decoder_scan_ctrl. Expected
// tables follow the build's DECODER_SCAN_BLANK_EN setting.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_i, abort_i, cont_i;
   logic [5:0] first_i, last_i;
   logic [7:0] dwell_i;
   logic [5:0] idx_o;
   logic       en_o, busy_o, done_o, wrap_o;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   decoder_scan_ctrl #(.K(6), .DWELL_W(8)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .start_i  (start_i),
      .first_i  (first_i),
      .last_i   (last_i),
      .dwell_i  (dwell_i),
      .cont_i   (cont_i),
      .abort_i  (abort_i),
      .idx_o    (idx_o),
      .en_o     (en_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .wrap_o   (wrap_o)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] p(input int idx, input int en, input int busy,
                                    input int done, input int wrap);
      return {idx[5:0], en[0], busy[0], done[0], wrap[0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {idx_o, en_o, busy_o, done_o, wrap_o};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed idx=%0d en=%0b busy=%0b done=%0b wrap=%0b expected idx=%0d en=%0b busy=%0b done=%0b wrap=%0b",
                tag, obs[9:4], obs[3], obs[2], obs[1], obs[0],
                exp[9:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Expected busy-state cycle (busy is always 1 while scanning).
   task automatic e(input int idx, input int en, input int done, input int wrap);
      exp_q.push_back(p(idx, en, 1, done, wrap));
   endtask

   // Checks queued cycles starting at the current one, stepping between them.
   task automatic run_exp(input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s_c%0d", tag, i), exp_q[i]);
         if (i < exp_q.size() - 1) step();
      end
      exp_q.delete();
   endtask

   task automatic push_s1();
`ifdef DECODER_SCAN_BLANK_EN
      e(3,1,0,0); e(3,1,0,0); e(4,0,0,0); e(4,1,0,0); e(4,1,0,0);
      e(5,0,0,0); e(5,1,0,0); e(5,1,0,0); e(5,0,1,0);
`else
      e(3,1,0,0); e(3,1,0,0); e(4,1,0,0); e(4,1,0,0);
      e(5,1,0,0); e(5,1,0,0); e(5,0,1,0);
`endif
   endtask

   initial begin
      start_i = 1'b0; abort_i = 1'b0; cont_i = 1'b0;
      first_i = '0;   last_i  = '0;   dwell_i = '0;

      // Reset
      #2 rst = 1'b1;
      #1 chk("rst_async", p(0,0,0,0,0));
      step();
      chk("rst_clk", p(0,0,0,0,0));
      rst = 1'b0;
      step();
      chk("idle", p(0,0,0,0,0));

      // Single pass 3..5, dwell 2
      first_i = 6'd3; last_i = 6'd5; dwell_i = 8'd2; cont_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      push_s1();
      run_exp("s1");
      step();
      chk("s1_idle", p(5,0,0,0,0));

      // Window wrapping through 2^K-1, dwell 1
      first_i = 6'd62; last_i = 6'd1; dwell_i = 8'd1; start_i = 1'b1;
      step();
      start_i = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      e(62,1,0,0); e(63,0,0,0); e(63,1,0,0); e(0,0,0,0); e(0,1,0,0);
      e(1,0,0,0);  e(1,1,0,0);  e(1,0,1,0);
`else
      e(62,1,0,0); e(63,1,0,0); e(0,1,0,0); e(1,1,0,0); e(1,0,1,0);
`endif
      run_exp("s2");
      step();
      chk("s2_idle", p(1,0,0,0,0));
      step();
      chk("s2_idle2", p(1,0,0,0,0));

      // Single-row continuous, dwell 0
      first_i = 6'd7; last_i = 6'd7; dwell_i = 8'd0; cont_i = 1'b1; start_i = 1'b1;
      step();
      start_i = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      e(7,1,0,0); e(7,0,0,0); e(7,1,0,1); e(7,0,0,0); e(7,1,0,1); e(7,0,0,0);
`else
      e(7,1,0,0); e(7,1,0,1); e(7,1,0,1); e(7,1,0,1); e(7,1,0,1); e(7,1,0,1);
`endif
      run_exp("s3");
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("s3_abort", p(7,0,0,0,0));

      // Continuous 0..3, dwell 3, abort in cycle 5
      first_i = 6'd0; last_i = 6'd3; dwell_i = 8'd3; cont_i = 1'b1; start_i = 1'b1;
      step();
      start_i = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      e(0,1,0,0); e(0,1,0,0); e(0,1,0,0); e(1,0,0,0); e(1,1,0,0); e(1,1,0,0);
`else
      e(0,1,0,0); e(0,1,0,0); e(0,1,0,0); e(1,1,0,0); e(1,1,0,0); e(1,1,0,0);
`endif
      run_exp("s4");
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("s4_abort", p(1,0,0,0,0));
      step();
      chk("s4_nodone", p(1,0,0,0,0));
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("s4_restart", p(0,1,1,0,0));
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("s4_abort2", p(0,0,0,0,0));

      // Start held while busy with changed configuration
      first_i = 6'd3; last_i = 6'd5; dwell_i = 8'd2; cont_i = 1'b0; start_i = 1'b1;
      step();
      first_i = 6'd10; last_i = 6'd20; dwell_i = 8'd5; cont_i = 1'b1;
      push_s1();
      run_exp("s5");
      start_i = 1'b0;
      step();
      chk("s5_idle", p(5,0,0,0,0));
      start_i = 1'b1; abort_i = 1'b1;
      step();
      start_i = 1'b0; abort_i = 1'b0;
      chk("s5_start_abort", p(5,0,0,0,0));
      step();
      chk("s5_still_idle", p(5,0,0,0,0));

      // Reset mid-row, then restart
      first_i = 6'd3; last_i = 6'd5; dwell_i = 8'd2; cont_i = 1'b0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      chk("s6_c1", p(3,1,1,0,0));
      #3 rst = 1'b1;
      #1 chk("s6_async", p(0,0,0,0,0));
      step();
      rst = 1'b0;
      chk("s6_held", p(0,0,0,0,0));
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("s6_restart", p(3,1,1,0,0));
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("s6_abort", p(3,0,0,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
